// File: rtl/buscador_pkg.sv
// Shared types and helpers for the binary-search guess generator.
package buscador_pkg;

    localparam int unsigned WidthPadrao = 16;

    typedef enum logic [2:0] {
        StInicial,
        StPropoe,
        StEspera,
        StAjusta,
        StFim,
        StErro
    } estado_e;

    // Counter must hold WIDTH+1 guesses plus the cleared value.
    function automatic int unsigned largura_tentativas(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/buscador_limites.sv
// Search-window datapath: lo/hi bounds, midpoint and lo > hi detection on the
// bounds about to be written.
module buscador_limites
    import buscador_pkg::*;
#(
    parameter int unsigned WIDTH = WidthPadrao
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             carrega_i,
    input  logic             ajusta_menor_i,
    input  logic             ajusta_maior_i,
    input  logic [WIDTH-1:0] palpite_i,
    output logic [WIDTH-1:0] meio_o,
    output logic             inconsistente_o
);

    localparam logic [WIDTH:0] HiInicial = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] Um        = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] lo_q, lo_d;
    logic [WIDTH:0] hi_q, hi_d;

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (carrega_i) begin
            lo_d = '0;
            hi_d = HiInicial;
        end else if (ajusta_menor_i) begin
            hi_d = {1'b0, palpite_i} - Um;
        end else if (ajusta_maior_i) begin
            lo_d = {1'b0, palpite_i} + Um;
        end
    end

    // hi only sets its MSB when it underflows to -1; lo only when it reaches 2^WIDTH.
    assign inconsistente_o = $signed({1'b0, lo_d}) > $signed({hi_d[WIDTH], hi_d});

    assign meio_o = WIDTH'(lo_q + ((hi_q - lo_q) >> 1));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lo_q <= '0;
            hi_q <= HiInicial;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/buscador_binario.sv
// Binary-search initiator driving the comparator B operand.
// Optional ESPERA timeout enabled with `define BUSCA_TIMEOUT_EN.
module buscador_binario
    import buscador_pkg::*;
#(
    parameter int unsigned WIDTH   = WidthPadrao,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   iniciar_i,
    input  logic                                   resp_valida_i,
    input  logic                                   alvo_menor_i,
    input  logic                                   alvo_maior_i,
    input  logic                                   alvo_igual_i,
    output logic [WIDTH-1:0]                       palpite_o,
    output logic                                   palpite_valido_o,
    output logic                                   pronto_o,
    output logic                                   erro_o,
    output logic [largura_tentativas(WIDTH)-1:0]   tentativas_o
);

    localparam int unsigned TentW = largura_tentativas(WIDTH);

    estado_e          estado_q, estado_d;
    logic [WIDTH-1:0] palpite_q, palpite_d;
    logic [TentW-1:0] tentativas_q, tentativas_d;
    logic             menor_q, menor_d;

    logic             carrega;
    logic             ajusta_menor;
    logic             ajusta_maior;
    logic             inconsistente;
    logic [WIDTH-1:0] meio;
    logic             timeout_atingido;

    buscador_limites #(
        .WIDTH (WIDTH)
    ) u_limites (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .carrega_i       (carrega),
        .ajusta_menor_i  (ajusta_menor),
        .ajusta_maior_i  (ajusta_maior),
        .palpite_i       (palpite_q),
        .meio_o          (meio),
        .inconsistente_o (inconsistente)
    );

`ifdef BUSCA_TIMEOUT_EN
    localparam int unsigned             EsperaW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [EsperaW-1:0]      EsperaUltimo = EsperaW'(TIMEOUT - 1);

    logic [EsperaW-1:0] espera_q, espera_d;

    // Held at zero outside ESPERA, so it is clear on every entry.
    always_comb begin
        espera_d = espera_q;
        if (estado_q != StEspera) begin
            espera_d = '0;
        end else if (!resp_valida_i) begin
            espera_d = espera_q + EsperaW'(1);
        end
    end

    assign timeout_atingido = (estado_q == StEspera) && !resp_valida_i &&
                              (espera_q == EsperaUltimo);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            espera_q <= '0;
        end else begin
            espera_q <= espera_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout   = ^TIMEOUT;
    assign timeout_atingido = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            estado_q <= StInicial;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StInicial, StFim, StErro: begin
                if (iniciar_i) estado_d = StPropoe;
            end
            StPropoe: estado_d = StEspera;
            StEspera: begin
                if (resp_valida_i) begin
                    if (!$onehot({alvo_menor_i, alvo_maior_i, alvo_igual_i})) begin
                        estado_d = StErro;
                    end else if (alvo_igual_i) begin
                        estado_d = StFim;
                    end else begin
                        estado_d = StAjusta;
                    end
                end else if (timeout_atingido) begin
                    estado_d = StErro;
                end
            end
            StAjusta: estado_d = inconsistente ? StErro : StPropoe;
            default:  estado_d = StInicial;
        endcase
    end

    always_comb begin
        palpite_valido_o = (estado_q == StEspera);
        pronto_o         = (estado_q == StFim);
        erro_o           = (estado_q == StErro);
        carrega          = iniciar_i && (estado_q inside {StInicial, StFim, StErro});
        ajusta_menor     = (estado_q == StAjusta) && menor_q;
        ajusta_maior     = (estado_q == StAjusta) && !menor_q;
    end

    always_comb begin
        palpite_d    = palpite_q;
        tentativas_d = tentativas_q;
        menor_d      = menor_q;
        if (carrega) begin
            tentativas_d = '0;
        end
        if (estado_q == StPropoe) begin
            palpite_d    = meio;
            tentativas_d = tentativas_q + TentW'(1);
        end
        if ((estado_q == StEspera) && resp_valida_i) begin
            menor_d = alvo_menor_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            palpite_q    <= '0;
            tentativas_q <= '0;
            menor_q      <= 1'b0;
        end else begin
            palpite_q    <= palpite_d;
            tentativas_q <= tentativas_d;
            menor_q      <= menor_d;
        end
    end

    assign palpite_o    = palpite_q;
    assign tentativas_o = tentativas_q;

endmodule

// File: tb/tb_buscador_binario.sv
// Bench for buscador_binario: directed searches against a comparator model and a
// plain integer binary-search reference.
module tb_buscador_binario;

    localparam int unsigned W         = 16;
    localparam int unsigned TW        = 5;
    localparam int unsigned TimeoutTb = 10;

    logic          clock;
    logic          reset;
    logic          iniciar;
    logic          resp_valida;
    logic          alvo_menor;
    logic          alvo_maior;
    logic          alvo_igual;
    logic [W-1:0]  palpite;
    logic          palpite_valido;
    logic          pronto;
    logic          erro;
    logic [TW-1:0] tentativas;

    int          vectors;
    int          miscompares;
    int unsigned exp_seq[$];
    int unsigned alvo_tb;
    bit          model_on;
    logic        resp_na_borda;
    logic        valido_ant;
    logic [W-1:0] palpite_ant;
    int          idx;

    buscador_binario #(
        .WIDTH   (W),
        .TIMEOUT (TimeoutTb)
    ) dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .iniciar_i        (iniciar),
        .resp_valida_i    (resp_valida),
        .alvo_menor_i     (alvo_menor),
        .alvo_maior_i     (alvo_maior),
        .alvo_igual_i     (alvo_igual),
        .palpite_o        (palpite),
        .palpite_valido_o (palpite_valido),
        .pronto_o         (pronto),
        .erro_o           (erro),
        .tentativas_o     (tentativas)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nome, input int unsigned atual, input int unsigned esperado);
        vectors++;
        if (atual !== esperado) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic falha(input string nome);
        vectors++;
        miscompares++;
        $display("FAIL %s: expected event never happened at %0t", nome, $time);
    endtask

    // Reference guess sequence from a plain integer binary search.
    function automatic void gera_sequencia(input int unsigned alvo);
        int unsigned lo;
        int unsigned hi;
        int unsigned m;
        exp_seq.delete();
        lo = 0;
        hi = (1 << W) - 1;
        for (int n = 0; n < 40; n++) begin
            m = (lo + hi) / 2;
            exp_seq.push_back(m);
            if (m == alvo) break;
            if (alvo < m) hi = m - 1;
            else lo = m + 1;
        end
    endfunction

    task automatic limpa_entradas();
        iniciar     = 1'b0;
        resp_valida = 1'b0;
        alvo_menor  = 1'b0;
        alvo_maior  = 1'b0;
        alvo_igual  = 1'b0;
    endtask

    task automatic espera_valido(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            iniciar = 1'b0;
            if (palpite_valido) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) falha("espera_valido");
    endtask

    // Full search answered by a comparator model; ciclos_esp < 0 skips the latency check.
    task automatic busca(input int unsigned alvo, input int atraso, input int ciclos_esp);
        int ciclos;
        int espera;
        bit fim;
        gera_sequencia(alvo);
        alvo_tb = alvo;
        @(negedge clock);
        iniciar = 1'b1;
        ciclos  = 0;
        espera  = 0;
        fim     = 1'b0;
        while (!fim && ciclos < 400) begin
            @(negedge clock);
            limpa_entradas();
            ciclos++;
            if (ciclos == 1) model_on = 1'b1;
            if (pronto || erro) begin
                fim = 1'b1;
            end else if (palpite_valido) begin
                if (espera == atraso) begin
                    resp_valida = 1'b1;
                    alvo_menor  = alvo < palpite;
                    alvo_maior  = alvo > palpite;
                    alvo_igual  = alvo == palpite;
                    espera      = 0;
                end else begin
                    espera++;
                end
            end
        end
        model_on = 1'b0;
        if (!fim) falha("busca_termina");
        check("busca_pronto", pronto, 1);
        check("busca_palpite", palpite, alvo);
        check("busca_tentativas", tentativas, exp_seq.size());
        if (ciclos_esp >= 0) check("busca_latencia", ciclos, ciclos_esp);
    endtask

    // Answers every guess with the same flag until erro shows up.
    task automatic responde_fixo(input bit menor);
        bit fim;
        fim = 1'b0;
        for (int i = 0; i < 200 && !fim; i++) begin
            @(negedge clock);
            limpa_entradas();
            if (erro) begin
                fim = 1'b1;
            end else if (palpite_valido) begin
                resp_valida = 1'b1;
                alvo_menor  = menor;
                alvo_maior  = !menor;
            end
        end
        if (!fim) falha("fixo_erro");
    endtask

    always @(posedge clock) resp_na_borda <= resp_valida;

    always @(negedge clock) begin
        if (model_on && !reset) begin
            if (palpite_valido) begin
                idx = int'(tentativas) - 1;
                if (idx >= 0 && idx < exp_seq.size()) check("palpite_seq", palpite, exp_seq[idx]);
                else check("tentativas_faixa", tentativas, exp_seq.size());
                check("estado_exclusivo", {pronto, erro}, 0);
            end
            if (valido_ant && !resp_na_borda) begin
                check("valido_mantido", palpite_valido, 1);
                check("palpite_mantido", palpite, palpite_ant);
            end
            if (pronto) begin
                check("final_palpite", palpite, alvo_tb);
                check("final_tentativas", tentativas, exp_seq.size());
            end
        end
        valido_ant  = palpite_valido;
        palpite_ant = palpite;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        vectors     = 0;
        miscompares = 0;
        model_on    = 1'b0;
        valido_ant  = 1'b0;
        limpa_entradas();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_palpite", palpite, 0);
        check("rst_valido", palpite_valido, 0);
        check("rst_pronto", pronto, 0);
        check("rst_erro", erro, 0);
        check("rst_tentativas", tentativas, 0);
        reset = 1'b0;

        // Responses outside ESPERA are ignored.
        resp_valida = 1'b1;
        alvo_igual  = 1'b1;
        repeat (3) @(negedge clock);
        limpa_entradas();
        check("resp_ignorada_pronto", pronto, 0);
        check("resp_ignorada_valido", palpite_valido, 0);

        // Pin the reference model with hand-computed values.
        gera_sequencia(0);
        check("modelo_zero_n", exp_seq.size(), 16);
        check("modelo_zero_2", exp_seq[1], 16'h3FFF);
        gera_sequencia(16'hFFFF);
        check("modelo_max_n", exp_seq.size(), 17);
        check("modelo_max_2", exp_seq[1], 16'hBFFF);

        busca(0, 0, 48);
        check("zero_tentativas_lit", tentativas, 16);
        busca(16'hFFFF, 0, 51);
        check("max_tentativas_lit", tentativas, 17);
        busca(16'h1234, 5, -1);
        check("atraso_palpite_lit", palpite, 16'h1234);
        busca(16'h7FFF, 0, 3);
        busca(16'h8000, 0, -1);

        // Two flags at once -> ERRO, then restart.
        @(negedge clock);
        iniciar = 1'b1;
        espera_valido(ok);
        resp_valida = 1'b1;
        alvo_menor  = 1'b1;
        alvo_maior  = 1'b1;
        @(negedge clock);
        limpa_entradas();
        check("duplo_erro", erro, 1);
        check("duplo_valido", palpite_valido, 0);
        check("duplo_palpite", palpite, 16'h7FFF);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("reinicio_erro_limpo", erro, 0);
        @(negedge clock);
        check("reinicio_valido", palpite_valido, 1);
        check("reinicio_palpite", palpite, 16'h7FFF);
        check("reinicio_tentativas", tentativas, 1);

        // iniciar in ESPERA is ignored.
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("iniciar_ignorado", palpite_valido, 1);
        check("iniciar_ignorado_tent", tentativas, 1);

        // Always "target smaller": palpite 0 is rejected without wrapping.
        responde_fixo(1'b1);
        check("menor_erro", erro, 1);
        check("menor_palpite", palpite, 0);
        check("menor_tentativas", tentativas, 16);
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        responde_fixo(1'b0);
        check("maior_erro", erro, 1);
        check("maior_palpite", palpite, 16'hFFFF);
        check("maior_tentativas", tentativas, 17);

        // Reset while waiting in ESPERA.
        @(negedge clock);
        iniciar = 1'b1;
        espera_valido(ok);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_meio_palpite", palpite, 0);
        check("rst_meio_valido", palpite_valido, 0);
        check("rst_meio_pronto", pronto, 0);
        check("rst_meio_erro", erro, 0);
        check("rst_meio_tentativas", tentativas, 0);
        @(negedge clock);
        check("rst_meio_inicial", palpite_valido, 0);

        // No response at all.
        iniciar = 1'b1;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            iniciar = 1'b0;
            if (erro) break;
            if (palpite_valido) n++;
        end
`ifdef BUSCA_TIMEOUT_EN
        check("timeout_erro", erro, 1);
        check("timeout_ciclos", n, TimeoutTb);
`else
        check("sem_timeout_valido", palpite_valido, 1);
        check("sem_timeout_erro", erro, 0);
        check("sem_timeout_ciclos", n, 999);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/buscador_binario.md
Name: buscador_binario

Overview:
- Sequential initiator that drives the B operand of the team's 16-bit magnitude comparator. The comparator compares a hidden target value (A) against the current guess (B).
- The block runs a binary search over [0, 2^WIDTH-1] from the comparator's less/greater/equal result. It stops when equality is reported.
- It sits in the game datapath between the control unit and the comparator. It replaces manual guess entry in automatic/demo mode.

Parameters:
- WIDTH, 16, operand width; must match the comparator.
- TIMEOUT, 255, maximum cycles spent in ESPERA. Used only with BUSCA_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  one-cycle pulse; starts a search. Ignored unless in INICIAL, FIM or ERRO.
- resp_valida  in  1  comparator result is valid this cycle.
- alvo_menor  in  1  target < palpite (comparator ALBo, with A=target, B=palpite).
- alvo_maior  in  1  target > palpite (comparator AGBo).
- alvo_igual  in  1  target == palpite (comparator AEBo).
- palpite  out  WIDTH  current guess; drives comparator B.
- palpite_valido  out  1  high while palpite is stable and awaiting a response.
- pronto  out  1  high in FIM; palpite holds the found value.
- erro  out  1  high in ERRO.
- tentativas  out  $clog2(WIDTH+2)  number of guesses issued in the current search.

Behaviour:
- Reset (synchronous, active-high, has priority over everything, including mid-search):
  - state=INICIAL; palpite=0; palpite_valido=0; pronto=0; erro=0; tentativas=0.
  - lo=0; hi=2^WIDTH-1.
- Internal bounds: lo and hi are WIDTH+1 bits wide so mid-1 and mid+1 never wrap.
- Guess arithmetic: mid = lo + ((hi - lo) >> 1), truncated to WIDTH bits for palpite.
- FSM states: INICIAL, PROPOE, ESPERA, AJUSTA, FIM, ERRO.
- INICIAL:
  - On iniciar: lo<=0; hi<=2^WIDTH-1; tentativas<=0; go to PROPOE.
- PROPOE (1 cycle):
  - palpite<=mid; tentativas<=tentativas+1; go to ESPERA.
- ESPERA:
  - palpite_valido=1 (combinational from state).
  - palpite and bounds are held stable until resp_valida=1.
  - On resp_valida, the flags must be exactly one-hot. Otherwise go to ERRO.
  - alvo_igual: go to FIM.
  - alvo_menor or alvo_maior: latch the flag and go to AJUSTA.
- AJUSTA (1 cycle):
  - If latched menor: hi<=palpite-1.
  - If latched maior: lo<=palpite+1.
  - Uses the extended-width compare on the new values. If new lo > new hi (inconsistent target), go to ERRO; otherwise go to PROPOE.
- FIM:
  - pronto=1; palpite held.
  - On iniciar: restart as from INICIAL (bounds reloaded, tentativas cleared, next state PROPOE).
- ERRO:
  - erro=1; palpite held.
  - On iniciar: restart identically to FIM.
- Latency per guess: 3 cycles (PROPOE, ESPERA, AJUSTA) when resp_valida arrives in the first ESPERA cycle.
- Guess bound: a consistent target is found in at most WIDTH+1 guesses.
- Boundaries:
  - palpite=0 with alvo_menor gives hi=-1 < lo → ERRO, with no wrap to all-ones.
  - palpite=2^WIDTH-1 with alvo_maior gives lo=2^WIDTH > hi → ERRO.
- resp_valida outside ESPERA is ignored.
- iniciar during PROPOE, ESPERA or AJUSTA is ignored.

Optional Feature:
- Macro: BUSCA_TIMEOUT_EN.
- With the macro: a cycle counter clears on entry to ESPERA and increments each ESPERA cycle without resp_valida. When it reaches TIMEOUT, go to ERRO.
- Without the macro: ESPERA waits indefinitely, and no counter logic is generated.

Decomposition:
- Package buscador_pkg holds:
  - the state enum (INICIAL..ERRO);
  - the default WIDTH;
  - the function computing the tentativas width, $clog2(WIDTH+2).
- Sub-module buscador_limites holds the datapath: lo/hi registers, mid calculation, extended-width lo>hi detection.
  - Control inputs: carrega, ajusta_menor, ajusta_maior.
  - The FSM stays in the top module.

Test Plan:
- WIDTH=16, target 0x0000 answered by a comparator model → guesses 0x7FFF, 0x3FFF, …, 0x0000; pronto after 16 guesses; tentativas=16.
- Target 0xFFFF → guesses 0x7FFF, 0xBFFF, …, 0xFFFF; pronto after 17 guesses, the maximum.
- Target 0x1234, resp_valida delayed 5 cycles on every guess → palpite and palpite_valido stable throughout each wait; final palpite=0x1234.
- Responses alvo_menor=1 and alvo_maior=1 in the same cycle → ERRO next cycle; erro=1; iniciar then restarts with palpite=0x7FFF.
- Model always answers alvo_menor → ERRO after palpite=0 is rejected, with no wrap; reset asserted in ESPERA mid-search → all outputs 0 next cycle.
- With BUSCA_TIMEOUT_EN and TIMEOUT=10, no resp_valida → erro asserted after exactly 10 ESPERA cycles; without the macro, still in ESPERA after 1000 cycles.
